// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 serial byte transmitter with selectable baud divisor
module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [7:0] Data_Byte,
    input  logic       Byte_En,
    input  logic [2:0] Baud_Set,
    output logic       Rs232_Tx,
    output logic       Tx_Done,
    output logic       Uart_State
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_nxt;
    logic [15:0] div, div_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  data, data_nxt;
    logic        tx_nxt, done_nxt, busy_nxt;
    logic        bit_end;

    function automatic logic [15:0] baud_div(input logic [2:0] code);
        case (code)
            3'd0:    baud_div = 16'(CLK_FREQ / 9600);
            3'd1:    baud_div = 16'(CLK_FREQ / 19200);
            3'd2:    baud_div = 16'(CLK_FREQ / 38400);
            3'd3:    baud_div = 16'(CLK_FREQ / 57600);
            3'd4:    baud_div = 16'(CLK_FREQ / 115200);
            3'd5:    baud_div = 16'(CLK_FREQ / 230400);
            3'd6:    baud_div = 16'(CLK_FREQ / 460800);
            default: baud_div = 16'(CLK_FREQ / 921600);
        endcase
    endfunction

    assign bit_end = (cnt == div - 16'd1);

    // All outputs are registered; the next values are decided here so the line never glitches.
    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        data_nxt  = data;
        tx_nxt    = Rs232_Tx;
        done_nxt  = 1'b0;
        busy_nxt  = Uart_State;

        if (state != IDLE) begin
            cnt_nxt = bit_end ? 16'd0 : cnt + 16'd1;
        end

        case (state)
            IDLE: begin
                if (Byte_En) begin
                    state_nxt = START;
                    data_nxt  = Data_Byte;
                    div_nxt   = baud_div(Baud_Set);
                    cnt_nxt   = 16'd0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                    tx_nxt    = data[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx == 3'd7) begin
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
                    end else begin
                        idx_nxt = idx + 3'd1;
                        tx_nxt  = data[idx + 3'd1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            div        <= 16'd0;
            cnt        <= 16'd0;
            idx        <= 3'd0;
            data       <= 8'd0;
            Rs232_Tx   <= 1'b1;
            Tx_Done    <= 1'b0;
            Uart_State <= 1'b0;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            data       <= data_nxt;
            Rs232_Tx   <= tx_nxt;
            Tx_Done    <= done_nxt;
            Uart_State <= busy_nxt;
        end
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Serial byte transmitter fed directly by the UART transmit-control stage. It accepts one byte per Byte_En strobe and selects its bit rate from the 3-bit Baud_Set code. It shifts out an 8N1 frame on Rs232_Tx and returns a single-cycle Tx_Done pulse to the control stage. Output drives the board RS-232 transceiver to the host PC.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; all bit-period divisors derive from it.

Ports:
Clk  input  1  system clock, rising-edge.
Rst_n  input  1  asynchronous active-low reset.
Data_Byte  input  8  byte to send; sampled only on the cycle Byte_En is accepted.
Byte_En  input  1  single-cycle start strobe from the transmit-control stage.
Baud_Set  input  3  baud code; sampled together with Data_Byte.
Rs232_Tx  output  1  serial line; idle high.
Tx_Done  output  1  one-cycle pulse when a frame completes.
Uart_State  output  1  high while a frame is in progress.

Behaviour:
- Reset is decided: Rst_n, asynchronous, active-low; clock Clk.
- Reset values: Rs232_Tx=1, Tx_Done=0, Uart_State=0, FSM=IDLE, all counters=0.
- Baud divisor DIV = CLK_FREQ/baud, integer truncation, registered at accept time:
  - codes 0..7 = 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
  - at 50 MHz: DIV = 5208, 2604, 1302, 868, 434, 217, 108, 54.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Byte_En=1 latches Data_Byte and the DIV derived from Baud_Set.
  - Next edge: state START, Uart_State=1, Rs232_Tx=0.
  - Latency from Byte_En sampled to line falling = 1 clock.
- Bit timer:
  - counts 0..DIV-1 within each bit.
  - the bit advances on the edge after the count reaches DIV-1.
  - each bit is exactly DIV clocks.
- START: line 0 for DIV clocks, then DATA with bit index 0.
- DATA: drives latched bit[index], LSB first; index 0..7. After bit 7 completes, go to STOP.
- STOP: line 1 for DIV clocks. On completion, next edge sets:
  - state IDLE, Uart_State=0, Tx_Done=1 for exactly one clock.
- Frame length: Rs232_Tx falling edge to Tx_Done rising = 10*DIV clocks.
- Byte_En while not IDLE is ignored; the latched byte and divisor are unaffected.
- Byte_En in the same cycle Tx_Done=1 is accepted, because the state is already IDLE. This gives back-to-back frames with no extra idle bit.
- Changes on Data_Byte or Baud_Set mid-frame have no effect.
- Rs232_Tx is registered and glitch-free; it never toggles within a bit period.
- Rst_n asserted mid-frame: line returns high immediately; no Tx_Done is generated; the frame is aborted.

Test Plan:
- Reset: hold Rst_n low 10 clocks -> Rs232_Tx=1, Tx_Done=0, Uart_State=0. Hold 200 clocks with no Byte_En -> outputs unchanged.
- Baud_Set=4, Data_Byte=0xA5, Byte_En pulse -> Rs232_Tx low 1 clock later. Sampled line at bit centres (217+434k) reads 0,1,0,1,0,0,1,0,1,1. Tx_Done pulses 1 clock at 4340 clocks after line fall; Uart_State falls at the same edge.
- Baud_Set=0, Data_Byte=0x00 -> start plus 8 data bits low for 9*5208 clocks, stop high 5208 clocks, Tx_Done at 52080 clocks.
- Mid-frame Byte_En with Data_Byte=0xFF and Baud_Set=7, during a 0x3C frame at code 4 -> transmitted frame is 0x3C at DIV=434. Only one Tx_Done occurs.
- Back-to-back: Byte_En coincident with Tx_Done, bytes 0x55 then 0xAA at code 7 -> second start bit begins 1 clock after Tx_Done. Total 2*540 clocks plus 1; two Tx_Done pulses.
- Reset mid-frame: assert Rst_n during data bit 3 -> Rs232_Tx=1 immediately, no Tx_Done. A new Byte_En after release sends a complete, correct frame.
